// File: rtl/alu_rs.sv
// ALU reservation station: holds issued ALU ops until both operands arrive on
// the CDB, then hands the lowest-index ready entry to a registered dispatch slot.
module alu_rs #(
  parameter int TAG_W = 4,
  parameter int DEPTH = 4,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [31:0]      issue_pc,
  input  logic [OP_W-1:0]  issue_op,
  input  logic [TAG_W-1:0] issue_tagx,
  input  logic [TAG_W-1:0] issue_tagy,
  input  logic [31:0]      issue_datax,
  input  logic [31:0]      issue_datay,
  input  logic [4:0]       issue_target,
  input  logic [TAG_W-1:0] issue_dest_tag,
  input  logic             cdb_en,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  output logic             disp_valid,
  input  logic             disp_ready,
  output logic [31:0]      disp_pc,
  output logic [OP_W-1:0]  disp_op,
  output logic [31:0]      disp_datax,
  output logic [31:0]      disp_datay,
  output logic [4:0]       disp_target,
  output logic [TAG_W-1:0] disp_dest_tag,
  output logic [2:0]       count
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] ent_v;
  logic [31:0]      ent_pc     [DEPTH];
  logic [OP_W-1:0]  ent_op     [DEPTH];
  logic [TAG_W-1:0] ent_tagx   [DEPTH];
  logic [TAG_W-1:0] ent_tagy   [DEPTH];
  logic [31:0]      ent_datax  [DEPTH];
  logic [31:0]      ent_datay  [DEPTH];
  logic [4:0]       ent_target [DEPTH];
  logic [TAG_W-1:0] ent_dtag   [DEPTH];

  logic [2:0]       cnt;
  logic             free_any, ready_any;
  logic [IW-1:0]    free_idx, ready_idx;
  logic             accept, cdb_hit, disp_load, take;
  logic [TAG_W-1:0] in_tagx, in_tagy;
  logic [31:0]      in_datax, in_datay;

  // Descending scan so the last hit is the lowest index.
  always_comb begin
    cnt       = '0;
    free_any  = 1'b0;
    free_idx  = '0;
    ready_any = 1'b0;
    ready_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!ent_v[i]) begin
        free_any = 1'b1;
        free_idx = IW'(i);
      end
      if (ent_v[i] && ent_tagx[i] == '0 && ent_tagy[i] == '0) begin
        ready_any = 1'b1;
        ready_idx = IW'(i);
      end
    end
    for (int i = 0; i < DEPTH; i++) cnt = cnt + 3'(ent_v[i]);
  end

  assign count       = cnt;
  assign issue_ready = rdy && (cnt < 3'(DEPTH));
  assign accept      = issue_valid && issue_ready && free_any && !flush;
  assign cdb_hit     = cdb_en && (cdb_tag != '0) && rdy && !flush;
  assign disp_load   = (!disp_valid || disp_ready) && rdy && !flush;
  assign take        = disp_load && ready_any;

  always_comb begin
    in_tagx  = issue_tagx;
    in_datax = issue_datax;
    in_tagy  = issue_tagy;
    in_datay = issue_datay;
    if (cdb_hit && cdb_tag == issue_tagx) begin
      in_tagx  = '0;
      in_datax = cdb_data;
    end
    if (cdb_hit && cdb_tag == issue_tagy) begin
      in_tagy  = '0;
      in_datay = cdb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_pc[i]     <= '0;
        ent_op[i]     <= '0;
        ent_tagx[i]   <= '0;
        ent_tagy[i]   <= '0;
        ent_datax[i]  <= '0;
        ent_datay[i]  <= '0;
        ent_target[i] <= '0;
        ent_dtag[i]   <= '0;
      end
    end else if (rdy) begin
      if (flush) begin
        ent_v <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (cdb_hit && ent_v[i] && ent_tagx[i] == cdb_tag) begin
            ent_tagx[i]  <= '0;
            ent_datax[i] <= cdb_data;
          end
          if (cdb_hit && ent_v[i] && ent_tagy[i] == cdb_tag) begin
            ent_tagy[i]  <= '0;
            ent_datay[i] <= cdb_data;
          end
          if (take && ready_idx == IW'(i)) ent_v[i] <= 1'b0;
          // Free index comes from registered valids, so a slot vacated by
          // this edge's dispatch is never the one written here.
          if (accept && free_idx == IW'(i)) begin
            ent_v[i]      <= 1'b1;
            ent_pc[i]     <= issue_pc;
            ent_op[i]     <= issue_op;
            ent_tagx[i]   <= in_tagx;
            ent_tagy[i]   <= in_tagy;
            ent_datax[i]  <= in_datax;
            ent_datay[i]  <= in_datay;
            ent_target[i] <= issue_target;
            ent_dtag[i]   <= issue_dest_tag;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_valid    <= 1'b0;
      disp_pc       <= '0;
      disp_op       <= '0;
      disp_datax    <= '0;
      disp_datay    <= '0;
      disp_target   <= '0;
      disp_dest_tag <= '0;
    end else if (rdy) begin
      if (flush) begin
        disp_valid <= 1'b0;
      end else if (disp_load) begin
        disp_valid <= ready_any;
        if (ready_any) begin
          disp_pc       <= ent_pc[ready_idx];
          disp_op       <= ent_op[ready_idx];
          disp_datax    <= ent_datax[ready_idx];
          disp_datay    <= ent_datay[ready_idx];
          disp_target   <= ent_target[ready_idx];
          disp_dest_tag <= ent_dtag[ready_idx];
        end
      end
    end
  end

endmodule
